main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm.sv | 184 ++++++++++++++++++
 tb/tb_main_control_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// Multicycle RISC-V main control FSM (Moore): sequences fetch/decode/execute
// and drives datapath selects and enables from the current state.
//
// Ports:
//   clk        - system clock, all state changes on rising edge
//   reset      - synchronous active-high reset
//   opcode     - instr[6:0] from the instruction register
//   zero       - ALU zero flag, used by BEQ
//   pc_write   - PC load enable (pc_update | branch & zero)
//   adr_src    - memory address select (0 PC, 1 ALU result reg)
//   mem_write  - data memory write enable
//   ir_write   - instruction register / old-PC load enable
//   result_src - result mux select
//   alu_src_a  - ALU A operand select
//   alu_src_b  - ALU B operand select
//   alu_op     - ALU decoder class code
//   reg_write  - register file write enable
//   illegal_op - high while trapped on an unknown opcode
//   state_o    - current state encoding for debug

module main_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t state;
    state_t next_state;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        illegal_op = 1'b0;
        state_o    = state;

        unique case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                next_state = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                unique case (opcode)
                    OP_LW,
                    OP_SW:   next_state = MEMADR;
                    OP_R:    next_state = EXECR;
                    OP_I:    next_state = EXECI;
                    OP_BEQ:  next_state = BEQ;
                    OP_JAL:  next_state = JAL;
                    default: next_state = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                next_state = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src    = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                next_state = FETCH;
            end
            EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                next_state = FETCH;
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                next_state = ALUWB;
            end
            TRAP: begin
                illegal_op = 1'b1;
                next_state = TRAP;
            end
            // Unused encodings are unreachable; fall back to fetch.
            default: next_state = FETCH;
        endcase

        // While reset is held the outputs already look like FETCH, but
        // without loading the PC or IR, so nothing is committed mid-reset.
        if (reset) begin
            pc_update  = 1'b0;
            branch     = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            result_src = 2'b10;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b10;
            alu_op     = 2'b00;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
            state_o    = 4'd0;
        end
    end

    assign pc_write = pc_update | (branch & zero);

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: expected output bundles are queued
// as each cycle is driven and popped/compared at the falling edge.

module tb_main_control_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state_o;

    main_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic [17:0] q[$];
    int vectors;
    int miscompares;

    // Bundle: {state_o, pc_write, adr_src, mem_write, ir_write,
    //          result_src, alu_src_a, alu_src_b, alu_op,
    //          reg_write, illegal_op}
    function automatic logic [17:0] model(input logic [3:0] st,
                                          input logic z,
                                          input logic rst);
        logic [3:0] s;
        logic pw, adr, mw, ir, rw, ill;
        logic [1:0] rs, sa, sbv, op;
        s = st;
        pw = 0; adr = 0; mw = 0; ir = 0; rw = 0; ill = 0;
        rs = 2'b00; sa = 2'b00; sbv = 2'b00; op = 2'b00;
        if (rst) begin
            s   = 4'd0;
            rs  = 2'b10;
            sbv = 2'b10;
        end else begin
            case (st)
                4'd0: begin ir = 1; pw = 1; sbv = 2'b10; rs = 2'b10; end
                4'd1: begin sa = 2'b01; sbv = 2'b01; end
                4'd2: begin sa = 2'b10; sbv = 2'b01; end
                4'd3: adr = 1;
                4'd4: begin rs = 2'b01; rw = 1; end
                4'd5: begin adr = 1; mw = 1; end
                4'd6: begin sa = 2'b10; op = 2'b10; end
                4'd7: begin sa = 2'b10; sbv = 2'b01; op = 2'b10; end
                4'd8: rw = 1;
                4'd9: begin sa = 2'b10; op = 2'b01; pw = z; end
                4'd10: begin sa = 2'b01; sbv = 2'b10; pw = 1; end
                4'd15: ill = 1;
                default: ;
            endcase
        end
        return {s, pw, adr, mw, ir, rs, sa, sbv, op, rw, ill};
    endfunction

    // Called just after a rising edge: drive inputs, queue the expected
    // bundle for this cycle, compare at the falling edge.
    task automatic cyc(input logic rst, input logic [6:0] op,
                       input logic z, input logic [3:0] st,
                       input string tag);
        logic [17:0] got;
        logic [17:0] want;
        reset  = rst;
        opcode = op;
        zero   = z;
        q.push_back(model(st, z, rst));
        @(negedge clk);
        got = {state_o, pc_write, adr_src, mem_write, ir_write,
               result_src, alu_src_a, alu_src_b, alu_op,
               reg_write, illegal_op};
        want = q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        opcode = 7'd0;
        zero   = 1'b0;
        @(posedge clk);
        #1;

        cyc(1, BAD, 1, 0, "rst_a");
        cyc(1, BAD, 1, 0, "rst_b");

        cyc(0, LW, 0, 0, "lw_fetch");
        cyc(0, LW, 1, 1, "lw_decode");
        cyc(0, LW, 0, 2, "lw_memadr");
        cyc(0, SW, 0, 3, "lw_memread");
        cyc(0, BAD, 0, 4, "lw_memwb");

        cyc(0, SW, 0, 0, "sw_fetch");
        cyc(0, SW, 0, 1, "sw_decode");
        cyc(0, SW, 0, 2, "sw_memadr");
        cyc(0, LW, 0, 5, "sw_memwrite");

        cyc(0, RT, 0, 0, "r_fetch");
        cyc(0, RT, 0, 1, "r_decode");
        cyc(0, BAD, 1, 6, "r_execr");
        cyc(0, BAD, 0, 8, "r_aluwb");

        cyc(0, IT, 0, 0, "i_fetch");
        cyc(0, IT, 0, 1, "i_decode");
        cyc(0, IT, 0, 7, "i_execi");
        cyc(0, IT, 0, 8, "i_aluwb");

        cyc(0, JL, 0, 0, "jal_fetch");
        cyc(0, JL, 0, 1, "jal_decode");
        cyc(0, JL, 0, 10, "jal_jal");
        cyc(0, JL, 0, 8, "jal_aluwb");

        cyc(0, BQ, 0, 0, "beq1_fetch");
        cyc(0, BQ, 0, 1, "beq1_decode");
        cyc(0, BQ, 1, 9, "beq_taken");

        cyc(0, BQ, 0, 0, "beq0_fetch");
        cyc(0, BQ, 1, 1, "beq0_decode");
        cyc(0, BQ, 0, 9, "beq_not_taken");

        cyc(0, BAD, 0, 0, "ill_fetch");
        cyc(0, BAD, 0, 1, "ill_decode");
        for (int i = 0; i < 10; i++) begin
            cyc(0, (i % 2 == 0) ? LW : RT, i[0], 15, "trap_hold");
        end
        cyc(1, LW, 0, 0, "trap_reset");
        cyc(0, LW, 0, 0, "trap_exit_fetch");

        cyc(0, LW, 0, 1, "mid_decode");
        cyc(0, LW, 0, 2, "mid_memadr");
        cyc(1, LW, 0, 3, "mid_reset_memread");
        cyc(0, RT, 0, 0, "mid_after_fetch");

        cyc(0, RT, 0, 1, "r2_decode");
        cyc(1, RT, 1, 6, "rst2_a_execr");
        cyc(1, RT, 1, 0, "rst2_b");
        cyc(0, RT, 1, 0, "rst2_release_fetch");
        cyc(0, RT, 0, 1, "rst2_decode");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
